udp_osd_frame_writer: RTL

- Write-side stage in the UDP receive clock domain.
- Parses OSD packets from the UDP payload byte stream and writes character/pixel bytes into the 2048x8 dual-clock OSD RAM through its write port.
- The RAM is used as two 1024-byte banks (ping-pong). Writes always go to the hidden bank; the visible bank flips only after a complete, valid packet, so the display-side reader never shows a torn frame.

---
 rtl/udp_osd_pkg.sv | 17 +
 rtl/udp_osd_frame_writer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/udp_osd_pkg.sv
// Shared constants and types for the OSD frame writer.
// No ports; imported by udp_osd_frame_writer.
package udp_osd_pkg;

    localparam logic [15:0] OSD_MAGIC      = 16'hA55A;
    localparam int unsigned OSD_HDR_BYTES  = 6;
    localparam int unsigned OSD_BANK_DEPTH = 1024;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        WAIT_LAST,
        DROP
    } osd_state_e;

endpackage

// File: rtl/udp_osd_frame_writer.sv
// Parses OSD packets from the UDP payload stream and writes them into the
// hidden half of a ping-pong OSD RAM; the visible bank flips only after a
// complete, valid packet.
// Ports:
//   clk, rst_n          UDP-domain clock, async active-low reset
//   s_data/valid/last   payload byte stream (no backpressure)
//   ram_wr_*            RAM write port (ram_wr_rst = ~rst_n)
//   disp_bank           bank shown by the reader (RAM address MSB)
//   frame_done          one-cycle pulse when disp_bank flips
//   err_pulse/err_cnt   per-rejected-packet pulse and saturating count
module udp_osd_frame_writer
    import udp_osd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [15:0] MAGIC      = OSD_MAGIC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic                  ram_wr_rst,
    output logic                  disp_bank,
    output logic                  frame_done,
    output logic                  err_pulse,
    output logic [15:0]           err_cnt
);

    localparam int unsigned OFF_W      = ADDR_WIDTH - 1;
    localparam int unsigned BANK_DEPTH = 1 << OFF_W;
    localparam logic [15:0] HDR_LAST   = 16'(OSD_HDR_BYTES - 1);

    osd_state_e       state;
    logic [39:0]      hdr_q;      // header bytes 0..4, newest in the low byte
    logic [15:0]      cnt;        // header byte index, then payload index
    logic [OFF_W-1:0] offset_q;
    logic [15:0]      length_q;
    logic             commit_q;   // flip pending: lands one cycle after the last write

    logic [15:0] magic_c;
    logic [15:0] off_c;
    logic [15:0] len_c;
    logic [16:0] sum_c;
    logic        hdr_ok_c;
    logic        hdr_end_c;
    logic        pay_end_c;
    logic        err_c;
    logic        commit_c;

    assign ram_wr_rst = ~rst_n;

    // Header check on the sixth byte and packet-level commit/error decisions
    always_comb begin
        magic_c   = hdr_q[39:24];
        off_c     = hdr_q[23:8];
        len_c     = {hdr_q[7:0], 8'(s_data)};
        sum_c     = 17'(off_c) + 17'(len_c);
        hdr_ok_c  = (magic_c == MAGIC) && ((off_c >> OFF_W) == 16'd0)
                    && (sum_c <= 17'(BANK_DEPTH));
        hdr_end_c = (state == HDR) && (cnt == HDR_LAST);
        pay_end_c = (state == PAYLOAD) && (cnt == length_q - 16'd1);
        err_c     = 1'b0;
        commit_c  = 1'b0;
        if (s_valid) begin
            case (state)
                IDLE: err_c = s_last;
                HDR: begin
                    if (!hdr_end_c)            err_c    = s_last;
                    else if (!hdr_ok_c)        err_c    = 1'b1;
                    else if (len_c == 16'd0)   commit_c = s_last;
                    else                       err_c    = s_last;
                end
                PAYLOAD: begin
                    if (pay_end_c) commit_c = s_last;
                    else           err_c    = s_last;
                end
                WAIT_LAST: commit_c = s_last;
                default: ;
            endcase
        end
    end

    // Packet FSM, write datapath and bank/error bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hdr_q       <= '0;
            cnt         <= '0;
            offset_q    <= '0;
            length_q    <= '0;
            commit_q    <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_wr_en   <= 1'b0;
            disp_bank   <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            ram_wr_en  <= 1'b0;
            frame_done <= commit_q;
            commit_q   <= commit_c;
            err_pulse  <= err_c;
            if (commit_q) disp_bank <= ~disp_bank;
            if (err_c && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;

            if (s_valid) begin
                case (state)
                    IDLE: begin
                        hdr_q <= {hdr_q[31:0], 8'(s_data)};
                        cnt   <= 16'd1;
                        state <= s_last ? IDLE : HDR;
                    end
                    HDR: begin
                        hdr_q <= {hdr_q[31:0], 8'(s_data)};
                        cnt   <= cnt + 16'd1;
                        if (hdr_end_c) begin
                            offset_q <= OFF_W'(off_c);
                            length_q <= len_c;
                            cnt      <= '0;
                            if (!hdr_ok_c)          state <= s_last ? IDLE : DROP;
                            else if (s_last)        state <= IDLE;
                            else if (len_c == 16'd0) state <= WAIT_LAST;
                            else                    state <= PAYLOAD;
                        end else if (s_last) begin
                            state <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= {~disp_bank, OFF_W'(16'(offset_q) + cnt)};
                        ram_wr_data <= s_data;
                        cnt         <= cnt + 16'd1;
                        if (s_last)         state <= IDLE;
                        else if (pay_end_c) state <= WAIT_LAST;
                    end
                    WAIT_LAST, DROP: begin
                        if (s_last) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
